ball_matcher: RTL and testbench

- Frame-level sequencer that assigns each tracked ball to the nearest unused detected candidate.
- It sits directly upstream and downstream of the 7-way `minimum` stage:
  - it builds the 7 distance values and the candidate count that drive the stage's inputs;
  - it consumes the returned `minimum_index` 2 cycles later.
- Candidates already claimed by earlier balls are masked, which gives a greedy one-to-one assignment for up to 7 balls per frame.

---
 rtl/ball_matcher.sv | 172 +++++++++++++++++
 tb/tb_ball_matcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_matcher.sv
// Greedy per-frame ball-to-candidate matcher wrapped around an external 7-way minimum stage.
// Each ball issues masked Manhattan distances, waits for the stage, then claims the returned candidate.
module ball_matcher #(
  parameter int X_WIDTH     = 11,
  parameter int Y_WIDTH     = 10,
  parameter int MIN_LATENCY = 2,
  parameter int DIST_SAT    = 510
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic [6:0][X_WIDTH-1:0]       ball_x_in,
  input  logic [6:0][Y_WIDTH-1:0]       ball_y_in,
  input  logic [2:0]                    ball_count_in,
  input  logic [6:0][X_WIDTH-1:0]       cand_x_in,
  input  logic [6:0][Y_WIDTH-1:0]       cand_y_in,
  input  logic [2:0]                    cand_count_in,
  output logic [6:0][8:0]               vals_out,
  output logic [2:0]                    max_out,
  input  logic [2:0]                    min_index_in,
  output logic [6:0][2:0]               assign_out,
  output logic [6:0]                    assign_valid_out,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [2:0]                    state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // WAIT is left on the cycle whose count equals WAIT_LAST, giving MIN_LATENCY-1 WAIT cycles.
  localparam int WAIT_LAST = (MIN_LATENCY > 1) ? MIN_LATENCY - 2 : 0;

  state_t state_q, state_d;

  logic [6:0][X_WIDTH-1:0] bx_q, cx_q;
  logic [6:0][Y_WIDTH-1:0] by_q, cy_q;
  logic [2:0]              ball_cnt_q, cand_cnt_q;
  logic [6:0]              used_q;
  logic [2:0]              b_q;
  logic [3:0]              wait_cnt_q;
  logic [6:0][2:0]         assign_q;
  logic [6:0]              valid_q;

  logic       used_full;
  logic       last_ball;
  logic       active;
  logic [11:0] dx, dy, sum, ax, ay, cxv, cyv;
  logic [8:0]  d;

  function automatic logic [3:0] popcount7(input logic [6:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < 7; k++) c = c + {3'd0, v[k]};
    return c;
  endfunction

  assign used_full = popcount7(used_q) >= {1'b0, cand_cnt_q};
  assign last_ball = (b_q == ball_cnt_q - 3'd1);
  assign active    = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) state_d = (ball_count_in == 3'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (used_full)             state_d = last_ball ? S_DONE : S_ISSUE;
        else if (MIN_LATENCY > 1)  state_d = S_WAIT;
        else                       state_d = S_CAPTURE;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST[3:0]) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = last_ball ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Frame datapath: latched inputs, used mask, ball pointer and results
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bx_q       <= '0;
      by_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      ball_cnt_q <= '0;
      cand_cnt_q <= '0;
      used_q     <= '0;
      b_q        <= '0;
      wait_cnt_q <= '0;
      assign_q   <= '0;
      valid_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            bx_q       <= ball_x_in;
            by_q       <= ball_y_in;
            cx_q       <= cand_x_in;
            cy_q       <= cand_y_in;
            ball_cnt_q <= ball_count_in;
            cand_cnt_q <= cand_count_in;
            used_q     <= '0;
            b_q        <= '0;
            valid_q    <= '0;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= '0;
          if (used_full) begin
            valid_q[b_q] <= 1'b0;
            b_q          <= b_q + 3'd1;
          end
        end
        S_WAIT: wait_cnt_q <= wait_cnt_q + 4'd1;
        S_CAPTURE: begin
          assign_q[b_q] <= min_index_in;
          valid_q[b_q]  <= 1'b1;
          if (min_index_in != 3'd7) used_q[min_index_in] <= 1'b1;
          b_q <= b_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Masked, saturated Manhattan distances from the current ball to every candidate
  always_comb begin
    vals_out = '0;
    ax  = 12'(bx_q[b_q]);
    ay  = 12'(by_q[b_q]);
    cxv = '0;
    cyv = '0;
    dx  = '0;
    dy  = '0;
    sum = '0;
    d   = '0;
    for (int i = 0; i < 7; i++) begin
      cxv = 12'(cx_q[i]);
      cyv = 12'(cy_q[i]);
      dx  = (ax >= cxv) ? ax - cxv : cxv - ax;
      dy  = (ay >= cyv) ? ay - cyv : cyv - ay;
      sum = dx + dy;
      d   = (sum > 12'(DIST_SAT)) ? 9'(DIST_SAT) : sum[8:0];
      if ((3'(i) >= cand_cnt_q) || used_q[i]) d = 9'd511;
      if (active) vals_out[i] = d;
    end
  end

  assign max_out          = cand_cnt_q;
  assign assign_out       = assign_q;
  assign assign_valid_out = valid_q;
  assign busy_out         = active;
  assign done_out         = (state_q == S_DONE);
  assign state_out        = state_q;

endmodule

// File: tb/tb_ball_matcher.sv
// Directed bench for ball_matcher with a 2-cycle argmin model standing in for the minimum stage.
module tb_ball_matcher;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [6:0][10:0]  ball_x, cand_x;
  logic [6:0][9:0]   ball_y, cand_y;
  logic [2:0]        ball_count, cand_count;
  logic [6:0][8:0]   vals;
  logic [2:0]        max_v;
  logic [2:0]        min_index;
  logic [6:0][2:0]   assign_v;
  logic [6:0]        assign_valid;
  logic              busy, done;
  logic [2:0]        state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ball_matcher dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .start_in         (start),
    .ball_x_in        (ball_x),
    .ball_y_in        (ball_y),
    .ball_count_in    (ball_count),
    .cand_x_in        (cand_x),
    .cand_y_in        (cand_y),
    .cand_count_in    (cand_count),
    .vals_out         (vals),
    .max_out          (max_v),
    .min_index_in     (min_index),
    .assign_out       (assign_v),
    .assign_valid_out (assign_valid),
    .busy_out         (busy),
    .done_out         (done),
    .state_out        (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Minimum stage model: lowest index among the smallest of the first max entries, 2 cycles later
  logic [2:0] pipe1 = '0;
  function automatic logic [2:0] argmin(input logic [6:0][8:0] v, input logic [2:0] m);
    logic [2:0] best;
    logic [9:0] bestv;
    best  = '0;
    bestv = 10'h3ff;
    for (int i = 0; i < 7; i++)
      if (3'(i) < m && {1'b0, v[i]} < bestv) begin
        best  = 3'(i);
        bestv = {1'b0, v[i]};
      end
    return best;
  endfunction

  initial min_index = '0;
  always @(posedge clk) begin
    pipe1     <= argmin(vals, max_v);
    min_index <= pipe1;
  end

  // Driver tasks
  task automatic clear_inputs();
    ball_x = '0; ball_y = '0; cand_x = '0; cand_y = '0;
    ball_count = '0; cand_count = '0;
  endtask

  task automatic set_ball(input int i, input int x, input int y);
    ball_x[i] = 11'(x); ball_y[i] = 10'(y);
  endtask

  task automatic set_cand(input int i, input int x, input int y);
    cand_x[i] = 11'(x); cand_y[i] = 10'(y);
  endtask

  task automatic identity_setup();
    clear_inputs();
    set_ball(0, 10, 10); set_ball(1, 200, 50); set_ball(2, 400, 300);
    set_cand(0, 10, 10); set_cand(1, 200, 50); set_cand(2, 400, 300);
    ball_count = 3'd3; cand_count = 3'd3;
  endtask

  // Starts a frame and observes max_cycles cycles; cycle 1 is the first after the accepting edge.
  // Snapshots vals at cycles 1, 4, 7; optionally pulses start with altered candidates at restart_cycle.
  task automatic run_frame(input int max_cycles, input int restart_cycle,
                           output int done_cycle, output logic [31:0] busy_vec,
                           output logic [6:0][8:0] s1, output logic [6:0][8:0] s4,
                           output logic [6:0][8:0] s7);
    done_cycle = -1;
    busy_vec   = '0;
    s1 = '0; s4 = '0; s7 = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= max_cycles; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == restart_cycle) begin
        start = 1'b1;
        cand_x[2] = 11'd900;
        ball_count = 3'd1;
      end
      if (k == 1) s1 = vals;
      if (k == 4) s4 = vals;
      if (k == 7) s7 = vals;
      busy_vec[k] = busy;
      if (done && done_cycle < 0) done_cycle = k;
    end
    start = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    total_cnt++;
    if ({vals, max_v, assign_v, assign_valid, busy, done} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d required 0", state_dbg);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity();
    int dc; logic [31:0] bv; logic [6:0][8:0] s1, s4, s7;
    identity_setup();
    run_frame(12, 0, dc, bv, s1, s4, s7);
    total_cnt++;
    if (dc !== 10) $display("FAIL identity_done_cycle: got %0d required 10", dc); else pass_cnt++;
    total_cnt++;
    if (assign_valid !== 7'b0000111) $display("FAIL identity_valid: got %b required 0000111", assign_valid); else pass_cnt++;
    total_cnt++;
    if (assign_v[2:0] !== 9'b010_001_000) $display("FAIL identity_assign: got %b required 010001000", assign_v[2:0]); else pass_cnt++;
    total_cnt++;
    if (bv[9:1] !== 9'h1ff || bv[11] !== 1'b0) $display("FAIL identity_busy: got %b required 1s in cycles 1-9, 0 in 11", bv[11:0]); else pass_cnt++;
    total_cnt++;
    if (s1[0] !== 9'd0 || s1[1] !== 9'd230 || s1[3] !== 9'd511) $display("FAIL identity_vals_b0: got %h required 0/230/511", s1); else pass_cnt++;
    total_cnt++;
    if (s7 !== {9'd511, 9'd511, 9'd511, 9'd511, 9'd0, 9'd511, 9'd511}) $display("FAIL identity_vals_b2: got %h", s7); else pass_cnt++;
    total_cnt++;
    if (max_v !== 3'd3) $display("FAIL identity_max: got %0d required 3", max_v); else pass_cnt++;
  endtask

  task automatic test_contention();
    int dc; logic [31:0] bv; logic [6:0][8:0] s1, s4, s7;
    clear_inputs();
    set_ball(0, 100, 100); set_ball(1, 104, 100);
    set_cand(0, 102, 100); set_cand(1, 300, 300);
    ball_count = 3'd2; cand_count = 3'd2;
    run_frame(10, 0, dc, bv, s1, s4, s7);
    total_cnt++;
    if (s1[0] !== 9'd2 || s1[1] !== 9'd400 || s1[2] !== 9'd511) $display("FAIL contention_vals_b0: got %0d %0d %0d required 2 400 511", s1[0], s1[1], s1[2]); else pass_cnt++;
    total_cnt++;
    if (s4[0] !== 9'd511 || s4[1] !== 9'd396) $display("FAIL contention_vals_b1: got %0d %0d required 511 396", s4[0], s4[1]); else pass_cnt++;
    total_cnt++;
    if (assign_v[1:0] !== 6'b001_000 || assign_valid !== 7'b0000011) $display("FAIL contention_assign: got %b/%b required 001000/0000011", assign_v[1:0], assign_valid); else pass_cnt++;
    total_cnt++;
    if (dc !== 7) $display("FAIL contention_done_cycle: got %0d required 7", dc); else pass_cnt++;
  endtask

  task automatic test_shortage();
    int dc; logic [31:0] bv; logic [6:0][8:0] s1, s4, s7;
    clear_inputs();
    set_ball(0, 0, 0); set_ball(1, 50, 0); set_ball(2, 100, 0); set_ball(3, 150, 0);
    set_cand(0, 48, 0); set_cand(1, 2, 0);
    ball_count = 3'd4; cand_count = 3'd2;
    run_frame(12, 0, dc, bv, s1, s4, s7);
    total_cnt++;
    if (dc !== 9) $display("FAIL shortage_done_cycle: got %0d required 9", dc); else pass_cnt++;
    total_cnt++;
    if (assign_valid !== 7'b0000011) $display("FAIL shortage_valid: got %b required 0000011", assign_valid); else pass_cnt++;
    total_cnt++;
    if (assign_v[1:0] !== 6'b000_001) $display("FAIL shortage_assign: got %b required 000001", assign_v[1:0]); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int dc; logic [31:0] bv; logic [6:0][8:0] s1, s4, s7;
    clear_inputs();
    set_ball(0, 0, 0); set_cand(0, 1279, 1023);
    ball_count = 3'd1; cand_count = 3'd1;
    run_frame(8, 0, dc, bv, s1, s4, s7);
    total_cnt++;
    if (s1 !== {9'd511, 9'd511, 9'd511, 9'd511, 9'd511, 9'd511, 9'd510}) $display("FAIL saturation_vals: got %h required 511x6,510", s1); else pass_cnt++;
    total_cnt++;
    if (assign_v[0] !== 3'd0 || assign_valid !== 7'b0000001 || dc !== 4) $display("FAIL saturation_result: got %0d/%b/%0d required 0/0000001/4", assign_v[0], assign_valid, dc); else pass_cnt++;
  endtask

  task automatic test_zero();
    int dc; logic [31:0] bv; logic [6:0][8:0] s1, s4, s7;
    clear_inputs();
    cand_count = 3'd3;
    run_frame(4, 0, dc, bv, s1, s4, s7);
    total_cnt++;
    if (dc !== 1) $display("FAIL zero_done_cycle: got %0d required 1", dc); else pass_cnt++;
    total_cnt++;
    if (assign_valid !== 7'b0 || bv[1] !== 1'b0) $display("FAIL zero_no_issue: got valid %b busy %b required 0/0", assign_valid, bv[1]); else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    int dc; logic [31:0] bv; logic [6:0][8:0] s1, s4, s7;
    identity_setup();
    run_frame(12, 5, dc, bv, s1, s4, s7);
    total_cnt++;
    if (dc !== 10 || assign_valid !== 7'b0000111) $display("FAIL ignored_start_frame: got done %0d valid %b required 10/0000111", dc, assign_valid); else pass_cnt++;
    total_cnt++;
    if (s7[2] !== 9'd0 || assign_v[2] !== 3'd2) $display("FAIL ignored_start_latch: got %0d/%0d required 0/2", s7[2], assign_v[2]); else pass_cnt++;
    identity_setup();
  endtask

  task automatic test_reset_mid_frame();
    int dc; logic [31:0] bv; logic [6:0][8:0] s1, s4, s7;
    logic seen_done;
    identity_setup();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (state_dbg !== 3'd2) $display("FAIL midreset_in_wait: got state %0d required 2", state_dbg); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({vals, max_v, assign_v, assign_valid, busy, done} !== '0) $display("FAIL midreset_outputs: got nonzero outputs, required all 0"); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    total_cnt++;
    if (seen_done !== 1'b0 || state_dbg !== 3'd0) $display("FAIL midreset_no_done: got done %b state %0d required 0/0", seen_done, state_dbg); else pass_cnt++;
    run_frame(12, 0, dc, bv, s1, s4, s7);
    total_cnt++;
    if (dc !== 10 || assign_valid !== 7'b0000111 || assign_v[2:0] !== 9'b010_001_000) $display("FAIL midreset_clean_frame: got %0d/%b/%b required 10/0000111/010001000", dc, assign_valid, assign_v[2:0]); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_inputs();
    #12;
    test_reset();
    test_identity();
    test_contention();
    test_shortage();
    test_saturation();
    test_zero();
    test_ignored_start();
    test_identity();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
